sw_debounce: RTL and testbench

SW_DEBOUNCE -- requirements
Module: sw_debounce

---
 rtl/sw_debounce_pkg.sv | 16 +
 rtl/sw_debounce_if.sv | 23 ++
 rtl/sw_debounce_bit.sv | 46 ++++
 rtl/sw_debounce.sv | 60 ++++++
 tb/tb_sw_debounce.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/sw_debounce_pkg.sv
// sw_debounce_pkg: shared defaults for the slide-switch debouncer.
//   SW_WIDTH_DEF   - default number of switch bits (a[3:0] low, b[3:0] high)
//   STABLE_CNT_DEF - default hold time in cycles (10 ms at 50 MHz)
//   STABLE_CNT_SIM - short hold time for simulation benches
//   cnt_width()    - width of a counter that must hold 0..n
package sw_debounce_pkg;

    localparam int SW_WIDTH_DEF   = 8;
    localparam int STABLE_CNT_DEF = 500000;
    localparam int STABLE_CNT_SIM = 4;

    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/sw_debounce_if.sv
// sw_debounce_if: switch-side bundle of the debouncer.
//   sw_raw  - bouncy, asynchronous switch levels (driven by master)
//   sw_db   - debounced levels; bits 3:0 are adder operand a, 7:4 operand b
//   sw_chg  - one-cycle pulse when any sw_db bit changes
//   sw_rise / sw_fall - per-bit edge pulses (only with SW_DEBOUNCE_EDGE_EN)
// Modports: master = switch/consumer side, slave = debouncer.
interface sw_debounce_if import sw_debounce_pkg::*; #(
    parameter int WIDTH = SW_WIDTH_DEF
);
    logic [WIDTH-1:0] sw_raw;
    logic [WIDTH-1:0] sw_db;
    logic             sw_chg;
`ifdef SW_DEBOUNCE_EDGE_EN
    logic [WIDTH-1:0] sw_rise;
    logic [WIDTH-1:0] sw_fall;

    modport master (output sw_raw, input sw_db, sw_chg, sw_rise, sw_fall);
    modport slave  (input sw_raw, output sw_db, sw_chg, sw_rise, sw_fall);
`else
    modport master (output sw_raw, input sw_db, sw_chg);
    modport slave  (input sw_raw, output sw_db, sw_chg);
`endif
endinterface

// File: rtl/sw_debounce_bit.sv
// debounce_bit: one switch bit -- 2-flop synchronizer, stability counter
// and debounced output flop.
//   clk, rst - clock and synchronous active-high reset
//   raw      - asynchronous switch level
//   db       - debounced level (registered)
//   upd      - combinational strobe: db loads the synced level at this edge
module debounce_bit import sw_debounce_pkg::*; #(
    parameter int STABLE_CNT = STABLE_CNT_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic db,
    output logic upd
);
    localparam int            CW   = cnt_width(STABLE_CNT);
    localparam logic [CW-1:0] LAST = CW'(STABLE_CNT - 1);

    logic          meta;
    logic          sync;
    logic [CW-1:0] cnt;

    // The mismatch has already been seen for STABLE_CNT-1 cycles; this is
    // the STABLE_CNT-th, so accept. The clear on acceptance bounds cnt.
    assign upd = (sync != db) && (cnt == LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= 1'b0;
            sync <= 1'b0;
            db   <= 1'b0;
            cnt  <= '0;
        end else begin
            meta <= raw;
            sync <= meta;
            if (sync == db) begin
                cnt <= '0;
            end else if (upd) begin
                db  <= sync;
                cnt <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end
endmodule

// File: rtl/sw_debounce.sv
// sw_debounce: WIDTH independent slide-switch debouncers.
//   clk_50mhz - single clock, rising edge
//   rst       - synchronous active-high reset
//   bus       - sw_debounce_if.slave: sw_raw in; sw_db, sw_chg out
//               (sw_rise/sw_fall too when SW_DEBOUNCE_EDGE_EN is defined)
// sw_db[3:0] / sw_db[7:4] feed the adder operands a / b directly.
// A clean sw_raw step reaches sw_db 2+STABLE_CNT cycles later.
// Optional feature macro: SW_DEBOUNCE_EDGE_EN adds per-bit edge pulses.
module sw_debounce import sw_debounce_pkg::*; #(
    parameter int WIDTH      = SW_WIDTH_DEF,
    parameter int STABLE_CNT = STABLE_CNT_DEF
) (
    input  logic          clk_50mhz,
    input  logic          rst,
    sw_debounce_if.slave  bus
);
    logic [WIDTH-1:0] db;
    logic [WIDTH-1:0] upd;
    logic             chg;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        debounce_bit #(.STABLE_CNT(STABLE_CNT)) u_bit (
            .clk (clk_50mhz),
            .rst (rst),
            .raw (bus.sw_raw[i]),
            .db  (db[i]),
            .upd (upd[i])
        );
    end

    assign bus.sw_db  = db;
    assign bus.sw_chg = chg;

    // Registered from the same strobes that load db, so the pulse lines up
    // with the first cycle showing the new sw_db value.
    always_ff @(posedge clk_50mhz) begin
        if (rst) chg <= 1'b0;
        else     chg <= |upd;
    end

`ifdef SW_DEBOUNCE_EDGE_EN
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;

    assign bus.sw_rise = rise;
    assign bus.sw_fall = fall;

    // db still holds the old level at the load edge, so its value tells the
    // direction of the update.
    always_ff @(posedge clk_50mhz) begin
        if (rst) begin
            rise <= '0;
            fall <= '0;
        end else begin
            rise <= upd & ~db;
            fall <= upd & db;
        end
    end
`endif
endmodule

// File: tb/tb_sw_debounce.sv
// tb_sw_debounce: directed bench for sw_debounce with STABLE_CNT=4, WIDTH=8.
// A value driven just after an edge is first sampled at the next edge
// (cycle 1); sw_db and sw_chg must show it at cycle 6 = 2+STABLE_CNT.
// Edge outputs are checked when SW_DEBOUNCE_EDGE_EN is defined.
module tb_sw_debounce;
    import sw_debounce_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vectors = 0;
    int   errors  = 0;

    sw_debounce_if #(.WIDTH(8)) bus ();

    sw_debounce #(.WIDTH(8), .STABLE_CNT(STABLE_CNT_SIM)) dut (
        .clk_50mhz (clk),
        .rst       (rst),
        .bus       (bus)
    );

    always #10 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives a level and waits long enough for it to be accepted.
    task automatic settle(input logic [7:0] v);
        bus.sw_raw = v;
        repeat (8) tick();
    endtask

    task automatic test_reset();
        logic [7:0] exp_db;
        logic       exp_chg;
        rst = 1'b1;
        bus.sw_raw = 8'hFF;
        repeat (3) begin
            tick();
            vectors++;
            if (bus.sw_db !== 8'h00 || bus.sw_chg !== 1'b0) begin
                errors++;
                $display("FAIL reset_hold db=%h chg=%b expected db=00 chg=0", bus.sw_db, bus.sw_chg);
            end
        end
        rst = 1'b0;
        for (int c = 1; c <= 7; c++) begin
            tick();
            exp_db  = (c >= 6) ? 8'hFF : 8'h00;
            exp_chg = (c == 6);
            vectors++;
            if (bus.sw_db !== exp_db || bus.sw_chg !== exp_chg) begin
                errors++;
                $display("FAIL reset_release c%0d db=%h chg=%b expected db=%h chg=%b", c, bus.sw_db, bus.sw_chg, exp_db, exp_chg);
            end
        end
    endtask

    task automatic test_bounce();
        logic [7:0] exp_db;
        int         pulses = 0;
        bus.sw_raw = 8'h00;
        for (int i = 0; i < 10; i++) begin
            bus.sw_raw[0] = (i % 2 == 0);
            tick();
            pulses += int'(bus.sw_chg);
            vectors++;
            if (bus.sw_db !== 8'h00) begin
                errors++;
                $display("FAIL bounce_toggle i%0d db=%h expected 00", i, bus.sw_db);
            end
        end
        bus.sw_raw[0] = 1'b1;
        for (int c = 1; c <= 7; c++) begin
            tick();
            pulses += int'(bus.sw_chg);
            exp_db = (c >= 6) ? 8'h01 : 8'h00;
            vectors++;
            if (bus.sw_db !== exp_db) begin
                errors++;
                $display("FAIL bounce_hold c%0d db=%h expected %h", c, bus.sw_db, exp_db);
            end
        end
        vectors++;
        if (pulses != 1) begin
            errors++;
            $display("FAIL bounce_chg_count got %0d expected 1", pulses);
        end
    endtask

    task automatic test_multi_bit();
        logic [7:0] exp_db;
        logic       exp_chg;
        bus.sw_raw = 8'h21;
        for (int c = 1; c <= 7; c++) begin
            tick();
            exp_db  = (c >= 6) ? 8'h21 : 8'h00;
            exp_chg = (c == 6);
            vectors++;
            if (bus.sw_db !== exp_db || bus.sw_chg !== exp_chg) begin
                errors++;
                $display("FAIL multi_bit c%0d db=%h chg=%b expected db=%h chg=%b", c, bus.sw_db, bus.sw_chg, exp_db, exp_chg);
            end
        end
    endtask

    task automatic test_glitch();
        bus.sw_raw = 8'h80;
        for (int c = 1; c <= 14; c++) begin
            if (c == 4) bus.sw_raw = 8'h00;
            tick();
            vectors++;
            if (bus.sw_db !== 8'h00 || bus.sw_chg !== 1'b0) begin
                errors++;
                $display("FAIL glitch c%0d db=%h chg=%b expected db=00 chg=0", c, bus.sw_db, bus.sw_chg);
            end
        end
    endtask

    // Exactly STABLE_CNT synced cycles of the new level is enough; the
    // return to 0 is then accepted too (raw back at cycle 5 -> db at 10).
    task automatic test_exact_hold();
        logic [7:0] exp_db;
        logic       exp_chg;
        bus.sw_raw = 8'h40;
        for (int c = 1; c <= 11; c++) begin
            if (c == 5) bus.sw_raw = 8'h00;
            tick();
            exp_db  = (c >= 6 && c <= 9) ? 8'h40 : 8'h00;
            exp_chg = (c == 6 || c == 10);
            vectors++;
            if (bus.sw_db !== exp_db || bus.sw_chg !== exp_chg) begin
                errors++;
                $display("FAIL exact_hold c%0d db=%h chg=%b expected db=%h chg=%b", c, bus.sw_db, bus.sw_chg, exp_db, exp_chg);
            end
        end
    endtask

    // Bit 3 bounces while bit 1 is being accepted; bit 1 keeps its timing.
    task automatic test_independent();
        logic [7:0] exp_db;
        logic       exp_chg;
        bus.sw_raw = 8'h02;
        for (int c = 1; c <= 10; c++) begin
            bus.sw_raw[3] = (c == 2 || c == 3 || c == 5);
            tick();
            exp_db  = (c >= 6) ? 8'h02 : 8'h00;
            exp_chg = (c == 6);
            vectors++;
            if (bus.sw_db !== exp_db || bus.sw_chg !== exp_chg) begin
                errors++;
                $display("FAIL independent c%0d db=%h chg=%b expected db=%h chg=%b", c, bus.sw_db, bus.sw_chg, exp_db, exp_chg);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] exp_db;
        logic       exp_chg;
        bus.sw_raw = 8'hFF;
        repeat (3) tick();
        rst = 1'b1;
        repeat (2) begin
            tick();
            vectors++;
            if (bus.sw_db !== 8'h00 || bus.sw_chg !== 1'b0) begin
                errors++;
                $display("FAIL reset_mid_hold db=%h chg=%b expected db=00 chg=0", bus.sw_db, bus.sw_chg);
            end
        end
        rst = 1'b0;
        for (int c = 1; c <= 7; c++) begin
            tick();
            exp_db  = (c >= 6) ? 8'hFF : 8'h00;
            exp_chg = (c == 6);
            vectors++;
            if (bus.sw_db !== exp_db || bus.sw_chg !== exp_chg) begin
                errors++;
                $display("FAIL reset_mid c%0d db=%h chg=%b expected db=%h chg=%b", c, bus.sw_db, bus.sw_chg, exp_db, exp_chg);
            end
        end
    endtask

`ifdef SW_DEBOUNCE_EDGE_EN
    task automatic test_edges();
        logic [7:0] exp_rise;
        logic [7:0] exp_fall;
        settle(8'h0F);
        bus.sw_raw = 8'hF0;
        for (int c = 1; c <= 7; c++) begin
            tick();
            exp_rise = (c == 6) ? 8'hF0 : 8'h00;
            exp_fall = (c == 6) ? 8'h0F : 8'h00;
            vectors++;
            if (bus.sw_rise !== exp_rise || bus.sw_fall !== exp_fall || bus.sw_chg !== (c == 6)) begin
                errors++;
                $display("FAIL edges c%0d rise=%h fall=%h chg=%b expected rise=%h fall=%h", c, bus.sw_rise, bus.sw_fall, bus.sw_chg, exp_rise, exp_fall);
            end
        end
    endtask
`endif

    initial begin
        bus.sw_raw = 8'h00;
        test_reset();
        settle(8'h00);
        test_bounce();
        settle(8'h00);
        test_multi_bit();
        settle(8'h00);
        test_glitch();
        test_exact_hold();
        settle(8'h00);
        test_independent();
        settle(8'h00);
        test_reset_mid();
        settle(8'h00);
`ifdef SW_DEBOUNCE_EDGE_EN
        test_edges();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
